// File: rtl/swin_pkg.sv
// Shared constants for the sliding-window line serializer: word width,
// line indices and the read-FSM state encoding.
package swin_pkg;

  localparam int WORD_WIDTH = 128;

  localparam logic [1:0] LINE0 = 2'd0;
  localparam logic [1:0] LINE1 = 2'd1;
  localparam logic [1:0] LINE2 = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L0   = 2'd1,
    L1   = 2'd2,
    L2   = 2'd3
  } state_t;

endpackage

// File: rtl/swin_win_fifo.sv
// Synchronous window FIFO; exposes the head entry and the entry behind it so
// the serializer can move to the next window without a bubble.
module swin_win_fifo #(
  parameter int WIDTH = 384,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] next_head,
  output logic             full,
  output logic             empty,
  output logic             single
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_inc;
  logic [PW-1:0]    fill;

  assign rd_ptr_inc = rd_ptr + PW'(1);
  assign fill       = wr_ptr - rd_ptr;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign next_head  = mem[rd_ptr_inc[AW-1:0]];
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign single     = (fill == PW'(1));

  // Pointer update; the extra MSB tells full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
    end
  end

  // Storage; a push while full lands in the slot being popped on the same edge.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/swin_line_serializer.sv
// Buffers 3-line windows and replays them as a ready/valid stream of line
// words (line 0, 1, 2), tagging frame ends and counting dropped windows.
module swin_line_serializer #(
  parameter int WORD_WIDTH    = swin_pkg::WORD_WIDTH,
  parameter int FIFO_DEPTH    = 4,
  parameter int WIN_PER_FRAME = 512,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] win_line_0,
  input  logic [WORD_WIDTH-1:0] win_line_1,
  input  logic [WORD_WIDTH-1:0] win_line_2,
  input  logic                  win_vld,
  output logic [WORD_WIDTH-1:0] m_data,
  output logic [1:0]            m_line_idx,
  output logic                  m_last,
  output logic                  m_vld,
  input  logic                  m_rdy,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  win_cnt
);

  import swin_pkg::*;

  localparam int EW = 3 * WORD_WIDTH;

  logic [EW-1:0]         wdata;
  logic [EW-1:0]         head;
  logic [EW-1:0]         next_head;
  logic [EW-1:0]         follow;
  logic                  full;
  logic                  empty;
  logic                  single;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  hs;
  logic                  frame_end;
  state_t                state;
  state_t                state_nxt;
  logic [WORD_WIDTH-1:0] data_nxt;
  logic [1:0]            idx_nxt;
  logic                  last_nxt;
  logic                  vld_nxt;

  assign wdata     = {win_line_2, win_line_1, win_line_0};
  assign hs        = m_vld && m_rdy;
  assign pop       = hs && (state == L2);
  assign push      = win_vld && (!full || pop);
  assign drop      = win_vld && full && !pop;
  assign frame_end = (win_cnt == CNT_WIDTH'(WIN_PER_FRAME - 1));
  // With one entry left and a push on the popping edge, the next window is the input itself.
  assign follow    = single ? wdata : next_head;

  swin_win_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .wdata     (wdata),
    .head      (head),
    .next_head (next_head),
    .full      (full),
    .empty     (empty),
    .single    (single)
  );

  // Next state and next registered beat.
  always_comb begin
    state_nxt = state;
    data_nxt  = m_data;
    idx_nxt   = m_line_idx;
    last_nxt  = m_last;
    vld_nxt   = m_vld;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt = L0;
          data_nxt  = head[WORD_WIDTH-1:0];
          idx_nxt   = LINE0;
          last_nxt  = 1'b0;
          vld_nxt   = 1'b1;
        end else begin
          vld_nxt   = 1'b0;
        end
      end
      L0: begin
        if (hs) begin
          state_nxt = L1;
          data_nxt  = head[2*WORD_WIDTH-1:WORD_WIDTH];
          idx_nxt   = LINE1;
        end else begin
          state_nxt = L0;
        end
      end
      L1: begin
        if (hs) begin
          state_nxt = L2;
          data_nxt  = head[3*WORD_WIDTH-1:2*WORD_WIDTH];
          idx_nxt   = LINE2;
          last_nxt  = frame_end;
        end else begin
          state_nxt = L1;
        end
      end
      L2: begin
        if (hs && (!single || push)) begin
          state_nxt = L0;
          data_nxt  = follow[WORD_WIDTH-1:0];
          idx_nxt   = LINE0;
          last_nxt  = 1'b0;
        end else if (hs) begin
          state_nxt = IDLE;
          data_nxt  = '0;
          idx_nxt   = LINE0;
          last_nxt  = 1'b0;
          vld_nxt   = 1'b0;
        end else begin
          state_nxt = L2;
        end
      end
      default: begin
        state_nxt = IDLE;
        vld_nxt   = 1'b0;
      end
    endcase
  end

  // State and output beat registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      m_data     <= '0;
      m_line_idx <= LINE0;
      m_last     <= 1'b0;
      m_vld      <= 1'b0;
    end else begin
      state      <= state_nxt;
      m_data     <= data_nxt;
      m_line_idx <= idx_nxt;
      m_last     <= last_nxt;
      m_vld      <= vld_nxt;
    end
  end

  // Frame position advances on each popped window; drops are counted separately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (pop) win_cnt <= frame_end ? '0 : win_cnt + CNT_WIDTH'(1);
      if (drop) overflow <= 1'b1;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_swin_line_serializer.sv
// Directed bench for swin_line_serializer with a scoreboard of expected beats.
module tb_swin_line_serializer;

  localparam int W   = 128;
  localparam int D   = 4;
  localparam int WPF = 3;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  win_line_0;
  logic [W-1:0]  win_line_1;
  logic [W-1:0]  win_line_2;
  logic          win_vld;
  logic [W-1:0]  m_data;
  logic [1:0]    m_line_idx;
  logic          m_last;
  logic          m_vld;
  logic          m_rdy;
  logic          overflow;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] win_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int acc      = 0;

  logic [W-1:0] exp_data [$];
  logic [1:0]   exp_idx  [$];
  logic         exp_last [$];

  swin_line_serializer #(
    .WORD_WIDTH    (W),
    .FIFO_DEPTH    (D),
    .WIN_PER_FRAME (WPF),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .win_line_0 (win_line_0),
    .win_line_1 (win_line_1),
    .win_line_2 (win_line_2),
    .win_vld    (win_vld),
    .m_data     (m_data),
    .m_line_idx (m_line_idx),
    .m_last     (m_last),
    .m_vld      (m_vld),
    .m_rdy      (m_rdy),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .win_cnt    (win_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input int w, input int l);
    return {32'(w), 32'(l), 32'hDEAD_BEEF, 32'(w * 3 + l)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic set_win(input int w);
    win_line_0 = mk(w, 0);
    win_line_1 = mk(w, 1);
    win_line_2 = mk(w, 2);
  endtask

  // Expected beats of an accepted window; frame end every WPF-th accepted window.
  task automatic add_win(input int w);
    for (int l = 0; l < 3; l++) begin
      exp_data.push_back(mk(w, l));
      exp_idx.push_back(2'(l));
      exp_last.push_back((l == 2) && ((acc % WPF) == WPF - 1));
    end
    acc++;
  endtask

  // One clock: drive m_rdy, score the presented beat, advance past the edge.
  task automatic cycle(input logic rdy);
    m_rdy = rdy;
    if (m_vld) begin
      if (exp_data.size() == 0) begin
        check("extra_beat", m_vld, 1'b0);
      end else begin
        check("beat_data", m_data, exp_data[0]);
        check("beat_idx", m_line_idx, exp_idx[0]);
        check("beat_last", m_last, exp_last[0]);
        if (rdy) begin
          void'(exp_data.pop_front());
          void'(exp_idx.pop_front());
          void'(exp_last.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    win_vld = 1'b0;
    m_rdy   = 1'b0;
    exp_data.delete();
    exp_idx.delete();
    exp_last.delete();
    acc = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drained(input string tag);
    check(tag, 128'(exp_data.size()), 128'd0);
    check({tag, "_vld"}, m_vld, 1'b0);
  endtask

  logic pat [16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                     1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int w;
    rst = 1'b1; win_vld = 1'b0; m_rdy = 1'b0;
    set_win(0);
    @(posedge clk);
    #1;
    check("rst_vld", m_vld, 1'b0);
    check("rst_data", m_data, '0);
    check("rst_idx", m_line_idx, 2'd0);
    check("rst_last", m_last, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_drop", drop_cnt, '0);
    check("rst_wcnt", win_cnt, '0);

    // Single window, first beat one cycle after the push.
    do_reset();
    m_rdy = 1'b1;
    set_win(1); win_vld = 1'b1; add_win(1);
    @(posedge clk);
    #1;
    win_vld = 1'b0;
    check("lat_idle", m_vld, 1'b0);
    cycle(1'b1);
    check("lat_first", m_vld, 1'b1);
    check("lat_idx", m_line_idx, 2'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1);
    drained("single_done");
    check("single_wcnt", win_cnt, 16'd1);

    // Backpressure: held words and exactly three beats.
    do_reset();
    set_win(2); win_vld = 1'b1; add_win(2);
    cycle(1'b0);
    win_vld = 1'b0;
    for (int i = 0; i < 16; i++) cycle(pat[i]);
    drained("bp_done");

    // Overflow: six windows into a stalled depth-4 FIFO.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      set_win(10 + i); win_vld = 1'b1;
      if (i <= 4) add_win(10 + i);
      cycle(1'b0);
    end
    win_vld = 1'b0;
    check("ovf_flag", overflow, 1'b1);
    check("ovf_drop", drop_cnt, 16'd2);
    for (int i = 0; i < 14; i++) cycle(1'b1);
    drained("ovf_done");
    check("ovf_drop_keep", drop_cnt, 16'd2);

    // Push on the same edge as the L2 pop while full is accepted.
    do_reset();
    for (int i = 21; i <= 24; i++) begin
      set_win(i); win_vld = 1'b1; add_win(i);
      cycle(1'b0);
    end
    win_vld = 1'b0;
    cycle(1'b1);
    cycle(1'b1);
    set_win(25); win_vld = 1'b1; add_win(25);
    cycle(1'b1);
    win_vld = 1'b0;
    check("fpp_drop", drop_cnt, 16'd0);
    check("fpp_ovf", overflow, 1'b0);
    for (int i = 0; i < 14; i++) cycle(1'b1);
    drained("fpp_done");

    // Framing: seven windows three cycles apart, m_last on beats 9 and 18.
    do_reset();
    w = 0;
    for (int c = 0; c < 30; c++) begin
      if ((c % 3 == 0) && (w < 7)) begin
        set_win(31 + w); win_vld = 1'b1; add_win(31 + w);
        w++;
      end else begin
        win_vld = 1'b0;
      end
      cycle(1'b1);
    end
    win_vld = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b1);
    drained("frame_done");
    check("frame_wcnt", win_cnt, 16'd1);

    // Asynchronous reset in the middle of a window.
    do_reset();
    for (int i = 41; i <= 45; i++) begin
      set_win(i); win_vld = 1'b1;
      if (i <= 44) add_win(i);
      cycle(1'b0);
    end
    win_vld = 1'b0;
    cycle(1'b1);
    check("mid_pre_idx", m_line_idx, 2'd1);
    check("mid_pre_ovf", overflow, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_vld", m_vld, 1'b0);
    check("mid_ovf", overflow, 1'b0);
    check("mid_drop", drop_cnt, 16'd0);
    check("mid_wcnt", win_cnt, 16'd0);
    check("mid_idx", m_line_idx, 2'd0);
    exp_data.delete(); exp_idx.delete(); exp_last.delete();
    acc = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_win(50); win_vld = 1'b1; add_win(50);
    cycle(1'b1);
    win_vld = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b1);
    drained("post_rst_done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
